// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the dm_lsu data memory.
// Holds the RISC-V funct3 size/sign codes, the controller state type, and
// helpers that decode access size and funct3 legality.
package dm_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic {CLEAR, RUN} state_e;

    // Access size in bytes. The low two funct3 bits encode log2(size).
    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    size_of = 1;
            2'd1:    size_of = 2;
            2'd2:    size_of = 4;
            default: size_of = 8;
        endcase
    endfunction

    // Load-side legality. Stores are further limited to codes with f3[2]=0.
    function automatic logic legal(input logic [2:0] f3, input int n);
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: legal = 1'b1;
            F3_D, F3_WU:                    legal = (n == 64);
            default:                        legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// dm_load_ext: selects the addressed bytes of a registered memory word and
// sign- or zero-extends them to N bits according to funct3.
module dm_load_ext
    import dm_pkg::*;
#(
    parameter int N = 32,
    localparam int OW = $clog2(N / 8)
) (
    input  logic [N-1:0]  word_i,
    input  logic [OW-1:0] off_i,
    input  logic [2:0]    funct3_i,
    output logic [N-1:0]  rd_o
);

    // Keep the low nbytes of v; fill the rest with the sign bit or zeros.
    function automatic logic [N-1:0] extend(input logic [N-1:0] v, input int nbytes,
                                            input logic sgn);
        logic top;
        top = sgn & v[8*nbytes-1];
        for (int i = 0; i < N; i++) begin
            extend[i] = (i < 8 * nbytes) ? v[i] : top;
        end
    endfunction

    logic [N-1:0] sh;

    // Align the addressed byte to bit 0, then extend per access type.
    always_comb begin
        sh = word_i >> {off_i, 3'b000};
        case (funct3_i)
            F3_B:    rd_o = extend(sh, 1, 1'b1);
            F3_BU:   rd_o = extend(sh, 1, 1'b0);
            F3_H:    rd_o = extend(sh, 2, 1'b1);
            F3_HU:   rd_o = extend(sh, 2, 1'b0);
            F3_W:    rd_o = extend(sh, 4, 1'b1);
            F3_WU:   rd_o = extend(sh, 4, 1'b0);
            default: rd_o = sh;
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// dm_lsu: byte-addressable data memory with RV32/RV64 load/store sizes,
// byte-lane writes, misalignment/illegal-code error pulses and one-cycle
// registered loads.
// Optional feature: define DMEM_CLEAR_EN to add a post-reset CLEAR state
// that zeroes every word before the block becomes ready.
module dm_lsu
    import dm_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH) + $clog2(N / 8)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    output logic          ready,
    input  logic          we,
    input  logic [2:0]    funct3,
    input  logic [AW-1:0] addr,
    input  logic [N-1:0]  wd,
    output logic          rvalid,
    output logic [N-1:0]  rd,
    output logic          err
);

    localparam int NB = N / 8;
    localparam int OW = $clog2(NB);
    localparam int IW = $clog2(DEPTH);

    logic [N-1:0]  mem [DEPTH];
    logic [OW-1:0] off;
    logic [IW-1:0] widx;
    logic          acc, bad, mis, we_ok;
    int            size;
    logic [NB-1:0] be;
    logic [N-1:0]  wsh;
    logic          ready_q, ready_d;
    logic          rvalid_q, err_q, zero_q;
    logic [N-1:0]  word_q, ext_rd;
    logic [OW-1:0] off_q;
    logic [2:0]    f3_q;

    assign off  = addr[OW-1:0];
    assign widx = addr[AW-1:OW];
    assign acc  = req && ready_q;

    // Decode size, alignment, legality and the byte-lane write pattern.
    always_comb begin
        size = size_of(funct3);
        mis  = 1'b0;
        for (int b = 0; b < OW; b++) begin
            if ((1 << b) < size) mis = mis | off[b];
        end
        bad   = !legal(funct3, N) || (we && funct3[2]) || mis;
        we_ok = acc && we && !bad;
        for (int b = 0; b < NB; b++) begin
            be[b] = (b >= int'(off)) && (b < int'(off) + size);
        end
        wsh = wd << {off, 3'b000};
    end

`ifdef DMEM_CLEAR_EN
    state_e        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          clr_we;

    // Controller state and clear-index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Walk the clear index; leave CLEAR once the last word has been zeroed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IW'(DEPTH - 1)) state_d = RUN;
        end
    end

    // Clear writes while in CLEAR; ready is registered from the next state.
    always_comb begin
        clr_we  = (state_q == CLEAR);
        ready_d = (state_d == RUN);
    end
`else
    assign ready_d = 1'b1;
`endif

    // Ready register: low during reset, rises once the controller is in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= ready_d;
    end

    // Memory array: clear writes, byte-lane stores, synchronous load capture.
    always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
        if (clr_we) mem[cnt_q] <= '0;
        else
`endif
        if (we_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wsh[8*b +: 8];
            end
        end
        if (acc && !we) begin
            word_q <= mem[widx];
            off_q  <= off;
            f3_q   <= funct3;
        end
    end

    // Response pulses; zero_q forces rd to 0 after reset and faulted loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            rvalid_q <= acc && !we;
            err_q    <= acc && bad;
            if (acc && !we) zero_q <= bad;
        end
    end

    dm_load_ext #(.N(N)) u_ext (
        .word_i   (word_q),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .rd_o     (ext_rd)
    );

    assign ready  = ready_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign rd     = zero_q ? '0 : ext_rd;

endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: drives identical request streams into an N=32 and an N=64
// dm_lsu and checks both against a byte-array reference model through
// per-instance scoreboards. Honours DMEM_CLEAR_EN for ready timing.
module tb_dm_lsu;

    localparam int DEPTH = 16;
`ifdef DMEM_CLEAR_EN
    localparam int EXP_LAT = DEPTH;
`else
    localparam int EXP_LAT = 1;
`endif

    typedef struct {
        logic        rv;
        logic        er;
        logic [63:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we;
    logic [2:0]  funct3;
    logic [6:0]  addr;
    logic [63:0] wd;
    logic        ready32, rvalid32, err32;
    logic [31:0] rd32;
    logic        ready64, rvalid64, err64;
    logic [63:0] rd64;

    exp_t        q32[$];
    exp_t        q64[$];
    logic [7:0]  mm[2][128];
    logic [63:0] hold32, hold64;
    logic        mon_en;
    int          checks, failures;

    always #5 clk = ~clk;

    dm_lsu #(.N(32), .DEPTH(DEPTH)) u32 (
        .clk(clk), .rst_n(rst_n), .req(req), .ready(ready32), .we(we),
        .funct3(funct3), .addr(addr[5:0]), .wd(wd[31:0]),
        .rvalid(rvalid32), .rd(rd32), .err(err32)
    );

    dm_lsu #(.N(64), .DEPTH(DEPTH)) u64 (
        .clk(clk), .rst_n(rst_n), .req(req), .ready(ready64), .we(we),
        .funct3(funct3), .addr(addr), .wd(wd),
        .rvalid(rvalid64), .rd(rd64), .err(err64)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: k=0 is the 32-bit instance, k=1 the 64-bit one.
    task automatic model(input int k, input logic w, input logic [2:0] f,
                         input logic [6:0] a, input logic [63:0] d);
        int n, nb, base, off, size;
        logic lg, bad;
        logic [63:0] v;
        exp_t e;
        n    = k ? 64 : 32;
        nb   = n / 8;
        base = int'(a) % (k ? 128 : 64);
        off  = base % nb;
        size = 1 << f[1:0];
        if (w) lg = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (n == 64 && f == 3'd3);
        else   lg = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5)
                    || (n == 64 && (f == 3'd3 || f == 3'd6));
        bad = !lg || (off % size != 0);
        e.rv = !w;
        e.er = bad;
        e.rd = '0;
        if (w && !bad) begin
            for (int i = 0; i < size; i++) mm[k][base + i] = d[8*i +: 8];
            return;
        end
        if (!w && !bad) begin
            v = '0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = mm[k][base + i];
            if (!f[2] && size * 8 < n && v[8*size-1])
                for (int i = 8 * size; i < n; i++) v[i] = 1'b1;
            e.rd = v;
        end
        if (k == 0) q32.push_back(e);
        else        q64.push_back(e);
    endtask

    // Called at a negedge; presents one request for the next rising edge.
    task automatic issue(input logic w, input logic [2:0] f, input logic [6:0] a,
                         input logic [63:0] d);
        req = 1'b1; we = w; funct3 = f; addr = a; wd = d;
        model(0, w, f, a, d);
        model(1, w, f, a, d);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready32"},  64'(ready32),  64'd0);
        check({tag, "_rvalid32"}, 64'(rvalid32), 64'd0);
        check({tag, "_err32"},    64'(err32),    64'd0);
        check({tag, "_rd32"},     64'(rd32),     64'd0);
        check({tag, "_ready64"},  64'(ready64),  64'd0);
        check({tag, "_rvalid64"}, 64'(rvalid64), 64'd0);
        check({tag, "_err64"},    64'(err64),    64'd0);
        check({tag, "_rd64"},     64'(rd64),     64'd0);
    endtask

    // Count rising edges after reset release until each instance is ready.
    task automatic measure_ready(input string tag);
        int c, l32, l64;
        c = 0; l32 = -1; l64 = -1;
        while ((l32 < 0 || l64 < 0) && c < 4 * DEPTH + 8) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            if (l32 < 0 && ready32) l32 = c;
            if (l64 < 0 && ready64) l64 = c;
        end
        check({tag, "_ready_lat32"}, 64'(l32), 64'(EXP_LAT));
        check({tag, "_ready_lat64"}, 64'(l64), 64'(EXP_LAT));
    endtask

    // Scoreboard monitor for the 32-bit instance.
    always @(negedge clk) begin : mon32
        exp_t e;
        if (mon_en && rst_n) begin
            if (rvalid32 || err32) begin
                if (q32.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL n32_unexpected rvalid=%b err=%b required=none", rvalid32, err32);
                end else begin
                    e = q32.pop_front();
                    check("n32_rvalid", 64'(rvalid32), 64'(e.rv));
                    check("n32_err", 64'(err32), 64'(e.er));
                    if (e.rv) begin
                        check("n32_rd", 64'(rd32), e.rd);
                        hold32 = e.rd;
                    end else check("n32_rd_hold", 64'(rd32), hold32);
                end
            end else check("n32_rd_idle", 64'(rd32), hold32);
        end
    end

    // Scoreboard monitor for the 64-bit instance.
    always @(negedge clk) begin : mon64
        exp_t e;
        if (mon_en && rst_n) begin
            if (rvalid64 || err64) begin
                if (q64.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL n64_unexpected rvalid=%b err=%b required=none", rvalid64, err64);
                end else begin
                    e = q64.pop_front();
                    check("n64_rvalid", 64'(rvalid64), 64'(e.rv));
                    check("n64_err", 64'(err64), 64'(e.er));
                    if (e.rv) begin
                        check("n64_rd", rd64, e.rd);
                        hold64 = e.rd;
                    end else check("n64_rd_hold", rd64, hold64);
                end
            end else check("n64_rd_idle", rd64, hold64);
        end
    end

    initial begin
        logic [2:0]  f;
        logic [6:0]  a;
        logic [63:0] d;
        checks = 0; failures = 0; mon_en = 1'b0;
        hold32 = '0; hold64 = '0;
        req = 1'b0; we = 1'b0; funct3 = '0; addr = '0; wd = '0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 128; i++) mm[k][i] = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        rst_n = 1'b1;
        measure_ready("first");

        // Reset in the middle of the clear walk (or idle traffic without it).
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midclear");
        @(negedge clk);
        rst_n = 1'b1;
        measure_ready("restart");

        // Reset right after a load is accepted drops its response.
        req = 1'b1; we = 1'b0; funct3 = 3'd2; addr = '0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        req = 1'b0;
        #1 check_reset_outputs("inflight");
        @(negedge clk);
        rst_n = 1'b1;
        measure_ready("after_inflight");

        hold32 = '0; hold64 = '0;
        mon_en = 1'b1;
`ifdef DMEM_CLEAR_EN
        issue(1'b0, 3'd2, 7'h00, 64'h0);
`endif
        for (int i = 0; i < 32; i++) issue(1'b1, 3'd2, 7'(4 * i), {32'h0, $urandom});

        issue(1'b1, 3'd2, 7'h10, 64'hDEADBEEF);
        issue(1'b0, 3'd0, 7'h13, 64'h0);
        issue(1'b0, 3'd4, 7'h13, 64'h0);
        issue(1'b0, 3'd1, 7'h12, 64'h0);
        issue(1'b0, 3'd5, 7'h10, 64'h0);
        issue(1'b1, 3'd2, 7'h20, 64'h11223344);
        issue(1'b1, 3'd0, 7'h21, 64'hAA);
        issue(1'b0, 3'd2, 7'h20, 64'h0);
        issue(1'b1, 3'd2, 7'h30, 64'hCAFEF00D);
        issue(1'b0, 3'd2, 7'h30, 64'h0);
        issue(1'b0, 3'd1, 7'h05, 64'h0);
        issue(1'b1, 3'd2, 7'h06, 64'h12345678);
        issue(1'b0, 3'd2, 7'h04, 64'h0);
        issue(1'b0, 3'd3, 7'h00, 64'h0);
        issue(1'b0, 3'd7, 7'h00, 64'h0);
        issue(1'b1, 3'd3, 7'h08, 64'h8000000000000001);
        issue(1'b0, 3'd2, 7'h0C, 64'h0);
        issue(1'b0, 3'd6, 7'h0C, 64'h0);
        issue(1'b0, 3'd3, 7'h08, 64'h0);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else begin
                f = 3'($urandom_range(0, 7));
                a = 7'($urandom_range(0, 127));
                if ($urandom_range(0, 1) == 1) a = a & ~7'((1 << f[1:0]) - 1);
                d = {$urandom, $urandom};
                issue(1'($urandom_range(0, 1)), f, a, d);
            end
        end
        idle(4);
        check("n32_queue_empty", 64'(q32.size()), 64'd0);
        check("n64_queue_empty", 64'(q64.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
